// File: rtl/pll_cen_gen.sv
// Multi-channel clock-enable generator driven by one fast PLL clock.
// Enables stay gated until the PLL lock has been synchronised and stable.
module pll_cen_gen #(
  parameter int                          NUM_CH      = 4,
  parameter int                          DIV_W       = 8,
  parameter logic [NUM_CH*DIV_W-1:0]     DIV_DEFAULT = 32'h10_08_02_04,
  parameter int                          LOCK_CYCLES = 16
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic                    pll_locked,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  input  logic                    div_load,
  input  logic                    resync,
  output logic [NUM_CH-1:0]       cen,
  output logic                    locked
);

  localparam int SW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;

  state_t            state, state_nxt;
  logic              sync1, locked_s;
  logic [SW-1:0]     settle_cnt, settle_nxt;
  logic [DIV_W-1:0]  div_active [NUM_CH];
  logic [DIV_W-1:0]  div_pend   [NUM_CH];
  logic [DIV_W-1:0]  cnt        [NUM_CH];
  logic [NUM_CH-1:0] pend_flag;

  // A divisor of 0 behaves like 1, so both reload to 0.
  function automatic logic [DIV_W-1:0] reload_of(input logic [DIV_W-1:0] d);
    return (d == '0) ? '0 : d - 1'b1;
  endfunction

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync1      <= 1'b0;
      locked_s   <= 1'b0;
      state      <= WAIT_LOCK;
      settle_cnt <= '0;
    end else begin
      sync1      <= pll_locked;
      locked_s   <= sync1;
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    settle_nxt = '0;
    case (state)
      WAIT_LOCK: begin
        if (locked_s) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (!locked_s)
          state_nxt = WAIT_LOCK;
        else if (settle_cnt == SW'(LOCK_CYCLES - 1))
          state_nxt = RUN;
        else
          settle_nxt = settle_cnt + 1'b1;
      end
      RUN: begin
        if (!locked_s) state_nxt = WAIT_LOCK;
      end
      default: state_nxt = WAIT_LOCK;
    endcase
  end

  // Pending divisors are adopted only at a terminal count (or resync) so the
  // running period always completes; a load in the same cycle wins over the clear.
  always_ff @(posedge refclk) begin
    if (rst) begin
      pend_flag <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        div_active[i] <= DIV_DEFAULT[i*DIV_W +: DIV_W];
        div_pend[i]   <= '0;
        cnt[i]        <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (state != RUN) begin
          cnt[i] <= '0;
        end else if (resync || cnt[i] == '0) begin
          if (pend_flag[i]) begin
            div_active[i] <= div_pend[i];
            pend_flag[i]  <= 1'b0;
          end
          if (resync)
            cnt[i] <= '0;
          else
            cnt[i] <= reload_of(pend_flag[i] ? div_pend[i] : div_active[i]);
        end else begin
          cnt[i] <= cnt[i] - 1'b1;
        end
        if (div_load) begin
          div_pend[i]  <= div_i[i*DIV_W +: DIV_W];
          pend_flag[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    locked = (state == RUN);
    for (int i = 0; i < NUM_CH; i++)
      cen[i] = (state == RUN) && (cnt[i] == '0);
  end

endmodule

// File: tb/tb_pll_cen_gen.sv
// Directed self-checking bench for pll_cen_gen with default parameters.
// Inputs change and outputs are sampled on the falling edge of refclk.
module tb_pll_cen_gen;

  localparam logic [31:0] DEF = 32'h10_08_02_04;

  logic        refclk;
  logic        rst;
  logic        pll_locked;
  logic [31:0] div_i;
  logic        div_load;
  logic        resync;
  logic [3:0]  cen;
  logic        locked;
  int          total;
  int          bad;

  pll_cen_gen dut (
    .refclk    (refclk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .div_i     (div_i),
    .div_load  (div_load),
    .resync    (resync),
    .cen       (cen),
    .locked    (locked)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic cycle();
    @(negedge refclk);
  endtask

  // Expected cen vector k cycles after an aligned start, given effective divisors.
  function automatic logic [3:0] exp_pat(int k, int d0, int d1, int d2, int d3);
    return {(k % d3) == 0, (k % d2) == 0, (k % d1) == 0, (k % d0) == 0};
  endfunction

  task automatic test_reset();
    logic [3:0] e_cen;
    rst = 1'b1; pll_locked = 1'b1;
    repeat (4) cycle();
    total++; if (cen !== 4'h0) begin bad++; $display("[TB] FAIL reset_cen: got %b expected 0000", cen); end
    total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL reset_locked: got %b expected 0", locked); end
    rst = 1'b0;
    for (int e = 1; e <= 19; e++) begin
      cycle();
      e_cen = (e == 19) ? 4'hf : 4'h0;
      total++; if (locked !== (e >= 19)) begin bad++; $display("[TB] FAIL lockup_locked e=%0d: got %b expected %b", e, locked, e >= 19); end
      total++; if (cen !== e_cen) begin bad++; $display("[TB] FAIL lockup_cen e=%0d: got %b expected %b", e, cen, e_cen); end
    end
    for (int k = 1; k <= 31; k++) begin
      cycle();
      e_cen = exp_pat(k, 4, 2, 8, 16);
      total++; if (cen !== e_cen || locked !== 1'b1) begin bad++; $display("[TB] FAIL default_pattern k=%0d: got cen=%b locked=%b expected cen=%b locked=1", k, cen, locked, e_cen); end
    end
  endtask

  task automatic test_lock_glitch();
    logic [3:0] e_cen;
    rst = 1'b1; cycle(); cycle(); rst = 1'b0;
    // One low sample at edge 8 restarts SETTLE, pushing RUN from edge 19 to 27.
    for (int e = 1; e <= 30; e++) begin
      pll_locked = (e != 8);
      cycle();
      total++; if (locked !== (e >= 27)) begin bad++; $display("[TB] FAIL settle_glitch_locked e=%0d: got %b expected %b", e, locked, e >= 27); end
      if (e <= 27) begin
        e_cen = (e == 27) ? 4'hf : 4'h0;
        total++; if (cen !== e_cen) begin bad++; $display("[TB] FAIL settle_glitch_cen e=%0d: got %b expected %b", e, cen, e_cen); end
      end
    end
    for (int e = 1; e <= 21; e++) begin
      pll_locked = !(e == 1 || e == 2);
      cycle();
      if (e < 3) begin
        total++; if (locked !== 1'b1) begin bad++; $display("[TB] FAIL run_drop_locked e=%0d: got %b expected 1", e, locked); end
      end else begin
        e_cen = (e == 21) ? 4'hf : 4'h0;
        total++; if (locked !== (e >= 21)) begin bad++; $display("[TB] FAIL run_drop_locked e=%0d: got %b expected %b", e, locked, e >= 21); end
        total++; if (cen !== e_cen) begin bad++; $display("[TB] FAIL run_drop_cen e=%0d: got %b expected %b", e, cen, e_cen); end
      end
    end
    for (int k = 1; k <= 15; k++) begin
      cycle();
      e_cen = exp_pat(k, 4, 2, 8, 16);
      total++; if (cen !== e_cen) begin bad++; $display("[TB] FAIL relock_pattern k=%0d: got %b expected %b", k, cen, e_cen); end
    end
  endtask

  task automatic test_reload();
    logic [3:0] e_cen;
    logic       e0;
    int         v;
    resync = 1'b1; cycle(); resync = 1'b0;
    total++; if (cen !== 4'hf) begin bad++; $display("[TB] FAIL reload_align: got %b expected 1111", cen); end
    // ch0: 4 until edge 5, then 6, then 3 (5 overwritten), then 4 loaded on a terminal edge.
    for (int k = 1; k <= 40; k++) begin
      v = (k == 2) ? 6 : (k == 12) ? 5 : (k == 14) ? 3 : (k == 29) ? 4 : 0;
      div_load = (v != 0);
      div_i    = {8'h10, 8'h08, 8'h02, 8'(v)};
      cycle();
      div_load = 1'b0;
      e0 = (k == 4) || (k == 10) || (k == 16) || (k == 19) || (k == 22) ||
           (k == 25) || (k == 28) || (k == 31) || (k == 35) || (k == 39);
      e_cen = {(k % 16) == 0, (k % 8) == 0, (k % 2) == 0, e0};
      total++; if (cen !== e_cen) begin bad++; $display("[TB] FAIL reload k=%0d: got %b expected %b", k, cen, e_cen); end
    end
  endtask

  task automatic test_div_zero_one();
    logic [3:0] e_cen;
    for (int d = 0; d <= 1; d++) begin
      div_i = {8'h10, 8'h08, 8'(d), 8'h04};
      div_load = 1'b1; cycle(); div_load = 1'b0;
      resync = 1'b1; cycle(); resync = 1'b0;
      total++; if (cen !== 4'hf) begin bad++; $display("[TB] FAIL div%0d_align: got %b expected 1111", d, cen); end
      for (int k = 1; k <= 15; k++) begin
        cycle();
        e_cen = exp_pat(k, 4, 1, 8, 16);
        total++; if (cen !== e_cen) begin bad++; $display("[TB] FAIL div%0d_ch1 k=%0d: got %b expected %b", d, k, cen, e_cen); end
      end
    end
  endtask

  task automatic test_resync();
    logic [3:0] e_cen;
    div_i = DEF;
    div_load = 1'b1; cycle(); div_load = 1'b0;
    resync = 1'b1; cycle(); resync = 1'b0;
    repeat (5) cycle();
    total++; if (cen !== exp_pat(5, 4, 2, 8, 16)) begin bad++; $display("[TB] FAIL resync_pre: got %b expected %b", cen, exp_pat(5, 4, 2, 8, 16)); end
    resync = 1'b1; cycle(); resync = 1'b0;
    total++; if (cen !== 4'hf) begin bad++; $display("[TB] FAIL resync_align: got %b expected 1111", cen); end
    for (int k = 1; k <= 16; k++) begin
      cycle();
      e_cen = exp_pat(k, 4, 2, 8, 16);
      total++; if (cen !== e_cen) begin bad++; $display("[TB] FAIL resync_pattern k=%0d: got %b expected %b", k, cen, e_cen); end
    end
    rst = 1'b1; cycle(); cycle(); rst = 1'b0;
    for (int e = 1; e <= 19; e++) begin
      resync = (e == 1 || e == 2);
      cycle();
      resync = 1'b0;
      e_cen = (e == 19) ? 4'hf : 4'h0;
      total++; if (locked !== (e >= 19) || cen !== e_cen) begin bad++; $display("[TB] FAIL resync_wait e=%0d: got locked=%b cen=%b expected locked=%b cen=%b", e, locked, cen, e >= 19, e_cen); end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [3:0] e_cen;
    div_i = {8'h10, 8'h08, 8'h03, 8'h04};
    div_load = 1'b1; cycle(); div_load = 1'b0;
    resync = 1'b1; cycle(); resync = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      e_cen = exp_pat(k, 4, 3, 8, 16);
      total++; if (cen !== e_cen) begin bad++; $display("[TB] FAIL ch1_div3 k=%0d: got %b expected %b", k, cen, e_cen); end
    end
    div_i = {8'h10, 8'h08, 8'h02, 8'h07};
    div_load = 1'b1; cycle(); div_load = 1'b0;
    rst = 1'b1; cycle();
    total++; if (cen !== 4'h0 || locked !== 1'b0) begin bad++; $display("[TB] FAIL midrun_reset: got cen=%b locked=%b expected cen=0000 locked=0", cen, locked); end
    rst = 1'b0;
    for (int e = 1; e <= 19; e++) begin
      cycle();
      total++; if (locked !== (e >= 19)) begin bad++; $display("[TB] FAIL midrun_relock e=%0d: got %b expected %b", e, locked, e >= 19); end
    end
    for (int k = 1; k <= 15; k++) begin
      cycle();
      e_cen = exp_pat(k, 4, 2, 8, 16);
      total++; if (cen !== e_cen) begin bad++; $display("[TB] FAIL midrun_defaults k=%0d: got %b expected %b", k, cen, e_cen); end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; pll_locked = 1'b0; div_i = DEF; div_load = 1'b0; resync = 1'b0;
    test_reset();
    test_lock_glitch();
    test_reload();
    test_div_zero_one();
    test_resync();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
